ddr3_mem_resp: RTL and testbench



---
 rtl/ddr3_mem_resp.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_ddr3_mem_resp.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_mem_resp.sv
// ddr3_mem_resp: device-side DDR3 responder (reduced-depth x8 part model).
// Decodes controller commands, tracks the open row per bank, stores BL8 write
// bursts and returns BL8 read bursts at a fixed CAS latency. Protocol and
// timing violations are ignored and reported through sticky flags.
//
// Ports:
//   cpu_clk, RESET            clock, synchronous active-high reset
//   cs_n/ras_n/cas_n/we_n     command strobes (active low)
//   ba, addr                  bank, row/column address, A10 = all-bank PRE
//   dq_wr_rise/dq_wr_fall     write beat (even/odd byte)
//   dq_rd_rise/dq_rd_fall     read beat (even/odd byte), zero when idle
//   dq_rd_valid               read beat valid
//   bank_open                 per-bank row-open status
//   err_state, err_timing     sticky protocol / timing violation flags
module ddr3_mem_resp #(
    parameter int unsigned ROW_W = 4,
    parameter int unsigned COL_W = 6,
    parameter int unsigned CL    = 5,
    parameter int unsigned CWL   = 5,
    parameter int unsigned TRCD  = 5,
    parameter int unsigned TRP   = 5
) (
    input  logic        cpu_clk,
    input  logic        RESET,
    input  logic        cs_n,
    input  logic        ras_n,
    input  logic        cas_n,
    input  logic        we_n,
    input  logic [2:0]  ba,
    input  logic [14:0] addr,
    input  logic [7:0]  dq_wr_rise,
    input  logic [7:0]  dq_wr_fall,
    output logic [7:0]  dq_rd_rise,
    output logic [7:0]  dq_rd_fall,
    output logic        dq_rd_valid,
    output logic [7:0]  bank_open,
    output logic        err_state,
    output logic        err_timing
);

    localparam int unsigned NB       = 8;
    localparam int unsigned TCCD     = 4;
    localparam int unsigned BYTE_AW  = 3 + ROW_W + COL_W;
    localparam int unsigned WORD_AW  = BYTE_AW - 1;
    localparam int unsigned DEPTH    = 2 ** WORD_AW;
    localparam int unsigned CNT_MAX0 = (TRCD > TRP) ? TRCD : TRP;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > TCCD) ? CNT_MAX0 : TCCD;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX);

    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_PRE = 3'b010;

    // Bank / command state
    logic [NB-1:0]      bank_open_q, bank_open_d;
    logic [ROW_W-1:0]   row_q [NB];
    logic [ROW_W-1:0]   row_d [NB];
    // One countdown per bank: TRCD while open, TRP while closed (0 = satisfied)
    logic [CNT_W-1:0]   bank_cnt_q [NB];
    logic [CNT_W-1:0]   bank_cnt_d [NB];
    logic [CNT_W-1:0]   ccd_cnt_q, ccd_cnt_d;
    logic               err_state_q, err_state_d;
    logic               err_timing_q, err_timing_d;

    // Latency delay lines: valid bit plus burst base word address
    logic [CL-1:0]      rd_vld_q, rd_vld_d;
    logic [WORD_AW-1:0] rd_base_q [CL];
    logic [WORD_AW-1:0] rd_base_d [CL];
    logic [CWL-1:0]     wr_vld_q, wr_vld_d;
    logic [WORD_AW-1:0] wr_base_q [CWL];
    logic [WORD_AW-1:0] wr_base_d [CWL];

    // Burst engines for beats 1..3 after the delay line releases beat 0
    logic               rd_act_q, rd_act_d;
    logic [1:0]         rd_beat_q, rd_beat_d;
    logic [WORD_AW-1:0] rd_bbase_q, rd_bbase_d;
    logic               wr_act_q, wr_act_d;
    logic [1:0]         wr_beat_q, wr_beat_d;
    logic [WORD_AW-1:0] wr_bbase_q, wr_bbase_d;

    logic [7:0]         dq_rd_rise_q, dq_rd_rise_d;
    logic [7:0]         dq_rd_fall_q, dq_rd_fall_d;
    logic               dq_rd_valid_q, dq_rd_valid_d;

    // Word array: one word = one beat = {fall byte, rise byte}
    logic [15:0]        mem_q [DEPTH];
    logic               mem_we_d;
    logic [WORD_AW-1:0] mem_waddr_d;
    logic [15:0]        mem_wdata_d;

    logic [2:0]         cmd_c;
    logic [WORD_AW-1:0] word_base_c;
    logic               rd_issue_c, wr_issue_c;
    logic               rd_fire_c;
    logic [WORD_AW-1:0] rd_word_c;
    logic               unused_addr_c;

    assign cmd_c         = {ras_n, cas_n, we_n};
    assign unused_addr_c = ^addr;

    // Burst base: column aligned to 8 bytes, expressed as a word (beat) address
    always_comb begin
        word_base_c      = {ba, row_q[ba], addr[COL_W-1:1]};
        word_base_c[1:0] = 2'b00;
    end

    // Command decode, legality checks and bank state update
    always_comb begin
        bank_open_d  = bank_open_q;
        ccd_cnt_d    = (ccd_cnt_q != '0) ? ccd_cnt_q - CNT_W'(1) : '0;
        err_state_d  = err_state_q;
        err_timing_d = err_timing_q;
        rd_issue_c   = 1'b0;
        wr_issue_c   = 1'b0;
        for (int i = 0; i < NB; i++) begin
            row_d[i]      = row_q[i];
            bank_cnt_d[i] = (bank_cnt_q[i] != '0) ? bank_cnt_q[i] - CNT_W'(1) : '0;
        end

        if (!cs_n) begin
            case (cmd_c)
                CMD_ACT: begin
                    if (bank_open_q[ba]) begin
                        err_state_d = 1'b1;
                    end else if (bank_cnt_q[ba] != '0) begin
                        err_timing_d = 1'b1;
                    end else begin
                        bank_open_d[ba] = 1'b1;
                        row_d[ba]       = addr[ROW_W-1:0];
                        bank_cnt_d[ba]  = CNT_W'(TRCD - 1);
                    end
                end
                CMD_RD, CMD_WR: begin
                    if (!bank_open_q[ba]) begin
                        err_state_d = 1'b1;
                    end else if ((bank_cnt_q[ba] != '0) || (ccd_cnt_q != '0)) begin
                        err_timing_d = 1'b1;
                    end else begin
                        ccd_cnt_d  = CNT_W'(TCCD - 1);
                        rd_issue_c = (cmd_c == CMD_RD);
                        wr_issue_c = (cmd_c == CMD_WR);
                    end
                end
                CMD_PRE: begin
                    if (addr[10]) begin
                        bank_open_d = '0;
                        for (int i = 0; i < NB; i++) begin
                            bank_cnt_d[i] = CNT_W'(TRP - 1);
                        end
                    end else if (!bank_open_q[ba]) begin
                        err_state_d = 1'b1;
                    end else begin
                        bank_open_d[ba] = 1'b0;
                        bank_cnt_d[ba]  = CNT_W'(TRP - 1);
                    end
                end
                default: ;  // NOP, REF, MRS and unlisted opcodes
            endcase
        end
    end

    // Delay lines: entry k holds a command accepted k+1 edges ago
    always_comb begin
        rd_vld_d     = {rd_vld_q[CL-2:0], rd_issue_c};
        wr_vld_d     = {wr_vld_q[CWL-2:0], wr_issue_c};
        rd_base_d[0] = word_base_c;
        wr_base_d[0] = word_base_c;
        for (int k = 1; k < CL; k++) begin
            rd_base_d[k] = rd_base_q[k-1];
        end
        for (int k = 1; k < CWL; k++) begin
            wr_base_d[k] = wr_base_q[k-1];
        end
    end

    // Read burst: beat 0 leaves the delay line, beats 1..3 follow back to back
    always_comb begin
        rd_act_d   = 1'b0;
        rd_beat_d  = rd_beat_q;
        rd_bbase_d = rd_bbase_q;
        rd_fire_c  = 1'b0;
        rd_word_c  = rd_bbase_q | WORD_AW'(rd_beat_q);
        if (rd_vld_q[CL-1]) begin
            rd_fire_c  = 1'b1;
            rd_word_c  = rd_base_q[CL-1];
            rd_act_d   = 1'b1;
            rd_beat_d  = 2'd1;
            rd_bbase_d = rd_base_q[CL-1];
        end else if (rd_act_q) begin
            rd_fire_c = 1'b1;
            rd_act_d  = (rd_beat_q != 2'd3);
            rd_beat_d = rd_beat_q + 2'd1;
        end
        dq_rd_valid_d = rd_fire_c;
        // Array is read at beat issue; a write landing on the same edge is not seen
        {dq_rd_fall_d, dq_rd_rise_d} = rd_fire_c ? mem_q[rd_word_c] : 16'h0000;
    end

    // Write burst: sample dq_wr on each beat edge; dropped while RESET is high
    always_comb begin
        wr_act_d    = 1'b0;
        wr_beat_d   = wr_beat_q;
        wr_bbase_d  = wr_bbase_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = wr_bbase_q | WORD_AW'(wr_beat_q);
        mem_wdata_d = {dq_wr_fall, dq_wr_rise};
        if (wr_vld_q[CWL-1]) begin
            mem_we_d    = !RESET;
            mem_waddr_d = wr_base_q[CWL-1];
            wr_act_d    = 1'b1;
            wr_beat_d   = 2'd1;
            wr_bbase_d  = wr_base_q[CWL-1];
        end else if (wr_act_q) begin
            mem_we_d  = !RESET;
            wr_act_d  = (wr_beat_q != 2'd3);
            wr_beat_d = wr_beat_q + 2'd1;
        end
    end

    // State registers
    always_ff @(posedge cpu_clk) begin
        if (RESET) begin
            bank_open_q   <= '0;
            ccd_cnt_q     <= '0;
            err_state_q   <= 1'b0;
            err_timing_q  <= 1'b0;
            rd_vld_q      <= '0;
            wr_vld_q      <= '0;
            rd_act_q      <= 1'b0;
            rd_beat_q     <= '0;
            rd_bbase_q    <= '0;
            wr_act_q      <= 1'b0;
            wr_beat_q     <= '0;
            wr_bbase_q    <= '0;
            dq_rd_rise_q  <= '0;
            dq_rd_fall_q  <= '0;
            dq_rd_valid_q <= 1'b0;
            for (int i = 0; i < NB; i++) begin
                row_q[i]      <= '0;
                bank_cnt_q[i] <= '0;
            end
            for (int k = 0; k < CL; k++) begin
                rd_base_q[k] <= '0;
            end
            for (int k = 0; k < CWL; k++) begin
                wr_base_q[k] <= '0;
            end
        end else begin
            bank_open_q   <= bank_open_d;
            ccd_cnt_q     <= ccd_cnt_d;
            err_state_q   <= err_state_d;
            err_timing_q  <= err_timing_d;
            rd_vld_q      <= rd_vld_d;
            wr_vld_q      <= wr_vld_d;
            rd_act_q      <= rd_act_d;
            rd_beat_q     <= rd_beat_d;
            rd_bbase_q    <= rd_bbase_d;
            wr_act_q      <= wr_act_d;
            wr_beat_q     <= wr_beat_d;
            wr_bbase_q    <= wr_bbase_d;
            dq_rd_rise_q  <= dq_rd_rise_d;
            dq_rd_fall_q  <= dq_rd_fall_d;
            dq_rd_valid_q <= dq_rd_valid_d;
            for (int i = 0; i < NB; i++) begin
                row_q[i]      <= row_d[i];
                bank_cnt_q[i] <= bank_cnt_d[i];
            end
            for (int k = 0; k < CL; k++) begin
                rd_base_q[k] <= rd_base_d[k];
            end
            for (int k = 0; k < CWL; k++) begin
                wr_base_q[k] <= wr_base_d[k];
            end
        end
    end

    // Storage array (contents survive reset)
    always_ff @(posedge cpu_clk) begin
        if (mem_we_d) begin
            mem_q[mem_waddr_d] <= mem_wdata_d;
        end
    end

    assign dq_rd_rise  = dq_rd_rise_q;
    assign dq_rd_fall  = dq_rd_fall_q;
    assign dq_rd_valid = dq_rd_valid_q;
    assign bank_open   = bank_open_q;
    assign err_state   = err_state_q;
    assign err_timing  = err_timing_q;

endmodule

// File: tb/tb_ddr3_mem_resp.sv
// tb_ddr3_mem_resp: directed scenarios plus randomized command traffic for
// ddr3_mem_resp, checked every cycle against a timestamp-based reference model.
module tb_ddr3_mem_resp;

    localparam int ROW_W = 4;
    localparam int COL_W = 6;
    localparam int CL    = 5;
    localparam int CWL   = 5;
    localparam int TRCD  = 5;
    localparam int TRP   = 5;
    localparam int TCCD  = 4;
    localparam int MEM_BYTES = 8 << (ROW_W + COL_W);

    localparam logic [2:0] C_NOP = 3'b111;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_MRS = 3'b000;

    logic        cpu_clk = 1'b0;
    logic        RESET = 1'b1;
    logic        cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [2:0]  ba = '0;
    logic [14:0] addr = '0;
    logic [7:0]  dq_wr_rise = '0, dq_wr_fall = '0;
    logic [7:0]  dq_rd_rise, dq_rd_fall;
    logic        dq_rd_valid;
    logic [7:0]  bank_open;
    logic        err_state, err_timing;

    ddr3_mem_resp #(
        .ROW_W(ROW_W), .COL_W(COL_W), .CL(CL), .CWL(CWL), .TRCD(TRCD), .TRP(TRP)
    ) dut (
        .cpu_clk    (cpu_clk),
        .RESET      (RESET),
        .cs_n       (cs_n),
        .ras_n      (ras_n),
        .cas_n      (cas_n),
        .we_n       (we_n),
        .ba         (ba),
        .addr       (addr),
        .dq_wr_rise (dq_wr_rise),
        .dq_wr_fall (dq_wr_fall),
        .dq_rd_rise (dq_rd_rise),
        .dq_rd_fall (dq_rd_fall),
        .dq_rd_valid(dq_rd_valid),
        .bank_open  (bank_open),
        .err_state  (err_state),
        .err_timing (err_timing)
    );

    always #5 cpu_clk = ~cpu_clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_n    = 0;

    // Reference model: times of last ACT/PRE/column command, byte array, beat schedules
    bit         m_open  [8];
    int         m_row   [8];
    int         m_act_t [8];
    int         m_pre_t [8];
    int         m_ccd_t;
    bit         m_err_s, m_err_t;
    logic [7:0] m_mem   [MEM_BYTES];
    bit         m_known [MEM_BYTES];
    int         rd_sched[int];
    int         wr_sched[int];
    bit         e_valid, e_known;
    logic [7:0] e_rise, e_fall;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc_n, got, exp);
        end
    endtask

    function automatic int byte_base(input int b, input int row, input int a);
        int col;
        col = a & ((1 << COL_W) - 1);
        return (b << (ROW_W + COL_W)) + (row << COL_W) + (col & ~7);
    endfunction

    function automatic logic [7:0] model_open_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_open[i];
        return v;
    endfunction

    task automatic model_cmd();
        int b, base;
        b = int'(ba);
        case ({ras_n, cas_n, we_n})
            C_ACT: begin
                if (m_open[b]) m_err_s = 1;
                else if (cyc_n - m_pre_t[b] < TRP) m_err_t = 1;
                else begin
                    m_open[b]  = 1;
                    m_row[b]   = int'(addr) & ((1 << ROW_W) - 1);
                    m_act_t[b] = cyc_n;
                end
            end
            C_RD, C_WR: begin
                if (!m_open[b]) m_err_s = 1;
                else if (cyc_n - m_act_t[b] < TRCD || cyc_n - m_ccd_t < TCCD) m_err_t = 1;
                else begin
                    base    = byte_base(b, m_row[b], int'(addr));
                    m_ccd_t = cyc_n;
                    for (int beat = 0; beat < 4; beat++) begin
                        if (we_n) rd_sched[cyc_n + CL + beat]  = base + 2 * beat;
                        else      wr_sched[cyc_n + CWL + beat] = base + 2 * beat;
                    end
                end
            end
            C_PRE: begin
                if (addr[10]) begin
                    for (int i = 0; i < 8; i++) begin
                        m_open[i]  = 0;
                        m_pre_t[i] = cyc_n;
                    end
                end else if (!m_open[b]) m_err_s = 1;
                else begin
                    m_open[b]  = 0;
                    m_pre_t[b] = cyc_n;
                end
            end
            default: ;
        endcase
    endtask

    // Expected effect of the clock edge numbered cyc_n
    task automatic model_edge();
        int a;
        e_valid = 0; e_known = 0; e_rise = '0; e_fall = '0;
        if (RESET) begin
            for (int i = 0; i < 8; i++) begin
                m_open[i] = 0; m_row[i] = 0; m_act_t[i] = -100; m_pre_t[i] = -100;
            end
            m_ccd_t = -100; m_err_s = 0; m_err_t = 0;
            rd_sched.delete();
            wr_sched.delete();
        end else begin
            if (rd_sched.exists(cyc_n)) begin
                a = rd_sched[cyc_n];
                e_valid = 1;
                e_known = m_known[a] && m_known[a+1];
                e_rise  = m_mem[a];
                e_fall  = m_mem[a+1];
            end
            if (wr_sched.exists(cyc_n)) begin
                a = wr_sched[cyc_n];
                m_mem[a] = dq_wr_rise; m_mem[a+1] = dq_wr_fall;
                m_known[a] = 1; m_known[a+1] = 1;
            end
            if (!cs_n) model_cmd();
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        model_edge();
        #1;
        chk("rd_valid", 32'(dq_rd_valid), 32'(e_valid));
        if (!e_valid) begin
            chk("rd_rise_idle", 32'(dq_rd_rise), 32'h0);
            chk("rd_fall_idle", 32'(dq_rd_fall), 32'h0);
        end else if (e_known) begin
            chk("rd_rise", 32'(dq_rd_rise), 32'(e_rise));
            chk("rd_fall", 32'(dq_rd_fall), 32'(e_fall));
        end
        chk("bank_open", 32'(bank_open), 32'(model_open_vec()));
        chk("err_state", 32'(err_state), 32'(m_err_s));
        chk("err_timing", 32'(err_timing), 32'(m_err_t));
        cyc_n++;
        dq_wr_rise = 8'($urandom);
        dq_wr_fall = 8'($urandom);
    endtask

    task automatic cyc_raw(input logic cs, input logic [2:0] cmd, input logic [2:0] b,
                           input logic [14:0] a);
        cs_n = cs;
        {ras_n, cas_n, we_n} = cmd;
        ba = b;
        addr = a;
        tick();
    endtask

    task automatic cyc(input logic [2:0] cmd, input logic [2:0] b, input logic [14:0] a);
        cyc_raw(1'b0, cmd, b, a);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        cyc(C_NOP, 3'd0, 15'd0);
        chk("rst_bank_open", 32'(bank_open), 32'h0);
        chk("rst_valid", 32'(dq_rd_valid), 32'h0);
        RESET = 1'b0;
    endtask

    function automatic logic [2:0] pick_bank(input bit want_open);
        int b;
        for (int t = 0; t < 8; t++) begin
            b = $urandom_range(0, 7);
            if (m_open[b] == want_open) return 3'(b);
        end
        return 3'($urandom_range(0, 7));
    endfunction

    initial begin
        int count;
        bit any_v;
        logic [2:0] b;
        logic [14:0] a;
        int r;

        do_reset();
        chk("rst_err_state", 32'(err_state), 32'h0);
        chk("rst_err_timing", 32'(err_timing), 32'h0);

        // Write then read back one burst in bank 2, row 3, column 8
        cyc(C_ACT, 3'd2, 15'd3);
        repeat (4) cyc(C_NOP, 3'd0, 15'd0);
        cyc(C_WR, 3'd2, 15'd8);
        repeat (CWL - 1) cyc(C_NOP, 3'd0, 15'd0);
        for (int i = 0; i < 4; i++) begin
            dq_wr_rise = 8'(8'h10 + 2 * i);
            dq_wr_fall = 8'(8'h11 + 2 * i);
            cyc(C_NOP, 3'd0, 15'd0);
        end
        cyc(C_RD, 3'd2, 15'd8);
        repeat (CL - 1) cyc(C_NOP, 3'd0, 15'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(C_NOP, 3'd0, 15'd0);
            chk("s1_valid", 32'(dq_rd_valid), 32'h1);
            chk("s1_rise", 32'(dq_rd_rise), 32'(8'h10 + 2 * i));
            chk("s1_fall", 32'(dq_rd_fall), 32'(8'h11 + 2 * i));
        end
        cyc(C_NOP, 3'd0, 15'd0);
        chk("s1_end_valid", 32'(dq_rd_valid), 32'h0);
        chk("s1_err", 32'({err_state, err_timing}), 32'h0);
        chk("s1_bank_open", 32'(bank_open), 32'h04);

        // Read to a closed bank
        cyc(C_RD, 3'd4, 15'd0);
        any_v = dq_rd_valid;
        cyc(C_NOP, 3'd0, 15'd0);
        chk("s2_err_state", 32'(err_state), 32'h1);
        chk("s2_bank_open", 32'(bank_open), 32'h04);
        repeat (CL + 4) begin
            cyc(C_NOP, 3'd0, 15'd0);
            any_v |= dq_rd_valid;
        end
        chk("s2_no_burst", 32'(any_v), 32'h0);

        // TRCD: early read rejected, read at TRCD accepted
        do_reset();
        cyc(C_ACT, 3'd0, 15'd1);
        cyc(C_NOP, 3'd0, 15'd0);
        cyc(C_RD, 3'd0, 15'd0);
        cyc(C_NOP, 3'd0, 15'd0);
        chk("s3_err_timing", 32'(err_timing), 32'h1);
        cyc(C_NOP, 3'd0, 15'd0);
        cyc(C_RD, 3'd0, 15'd0);
        count = 0;
        repeat (9) begin
            cyc(C_NOP, 3'd0, 15'd0);
            count += int'(dq_rd_valid);
        end
        chk("s3_burst_len", 32'(count), 32'd4);

        // tCCD: gapless reads 4 apart, third read 2 later rejected
        do_reset();
        cyc(C_ACT, 3'd3, 15'd5);
        repeat (4) cyc(C_NOP, 3'd0, 15'd0);
        cyc(C_RD, 3'd3, 15'd0);
        for (int k = 1; k <= 16; k++) begin
            if (k == 4)      cyc(C_RD, 3'd3, 15'd16);
            else if (k == 6) cyc(C_RD, 3'd3, 15'd24);
            else             cyc(C_NOP, 3'd0, 15'd0);
            chk("s4_valid", 32'(dq_rd_valid), 32'(k >= 5 && k <= 12));
        end
        chk("s4_err_timing", 32'(err_timing), 32'h1);
        chk("s4_err_state", 32'(err_state), 32'h0);

        // PRE all, then TRP on re-activation
        do_reset();
        cyc(C_ACT, 3'd1, 15'd0);
        cyc(C_ACT, 3'd5, 15'd2);
        chk("s5_open_two", 32'(bank_open), 32'h22);
        cyc(C_PRE, 3'd0, 15'h0400);
        chk("s5_pre_all", 32'(bank_open), 32'h00);
        chk("s5_pre_err", 32'({err_state, err_timing}), 32'h0);
        cyc(C_NOP, 3'd0, 15'd0);
        cyc(C_NOP, 3'd0, 15'd0);
        cyc(C_ACT, 3'd1, 15'd7);
        cyc(C_NOP, 3'd0, 15'd0);
        chk("s5_trp_err", 32'(err_timing), 32'h1);
        chk("s5_trp_open", 32'(bank_open), 32'h00);
        cyc(C_ACT, 3'd1, 15'd7);
        chk("s5_act_ok", 32'(bank_open), 32'h02);

        // Reset in the middle of a read burst
        repeat (4) cyc(C_NOP, 3'd0, 15'd0);
        cyc(C_RD, 3'd1, 15'd8);
        repeat (CL) cyc(C_NOP, 3'd0, 15'd0);
        chk("s6_beat0", 32'(dq_rd_valid), 32'h1);
        RESET = 1'b1;
        cyc(C_NOP, 3'd0, 15'd0);
        chk("s6_rst_valid", 32'(dq_rd_valid), 32'h0);
        chk("s6_rst_open", 32'(bank_open), 32'h00);
        chk("s6_rst_err", 32'({err_state, err_timing}), 32'h0);
        RESET = 1'b0;
        repeat (4) begin
            cyc(C_NOP, 3'd0, 15'd0);
            chk("s6_dropped", 32'(dq_rd_valid), 32'h0);
        end

        // Randomized traffic, biased toward legal commands on a few rows/columns
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            a = 15'($urandom);
            RESET = ($urandom_range(0, 599) == 0);
            if (r < 35) begin
                cyc(C_NOP, 3'd0, a);
            end else if (r < 42) begin
                cyc_raw(1'b1, 3'($urandom), 3'($urandom), a);
            end else if (r < 57) begin
                b = pick_bank(1'b0);
                a[ROW_W-1:0] = ROW_W'($urandom_range(0, 1));
                cyc(C_ACT, b, a);
            end else if (r < 72) begin
                b = pick_bank(1'b1);
                a[COL_W-1:0] = COL_W'($urandom_range(0, 23));
                cyc(C_RD, b, a);
            end else if (r < 87) begin
                b = pick_bank(1'b1);
                a[COL_W-1:0] = COL_W'($urandom_range(0, 23));
                cyc(C_WR, b, a);
            end else if (r < 96) begin
                b = ($urandom_range(0, 3) == 0) ? 3'($urandom) : pick_bank(1'b1);
                a[10] = ($urandom_range(0, 3) == 0);
                cyc(C_PRE, b, a);
            end else begin
                cyc(($urandom_range(0, 1) == 0) ? C_REF : C_MRS, 3'($urandom), a);
            end
        end
        RESET = 1'b0;
        repeat (CL + 6) cyc(C_NOP, 3'd0, 15'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
